// File: rtl/frame_writer.sv
// Turns the OV7670 capture-stage pixel stream into linear frame-buffer writes in the pclk
// domain, tracking rows from href/vsync with optional 2x2 decimation.
module frame_writer #(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned DECIM    = 1,
   parameter int unsigned ADDR_W   = 17
) (
   input  logic              pclk,
   input  logic              rst_n,
   input  logic              vsync,
   input  logic              href,
   input  logic [11:0]       pix_rgb,
   input  logic [9:0]        pix_col,
   input  logic              pix_valid,
   output logic [ADDR_W-1:0] fb_addr,
   output logic [11:0]       fb_data,
   output logic              fb_we,
   output logic              frame_done,
   output logic              frame_short,
   output logic              overflow
);

   localparam int unsigned ROW_W = 9;
   localparam int unsigned COL_W = 10;
   localparam logic [ROW_W-1:0]  ROW_MAX   = '1;
   localparam logic [ADDR_W-1:0] BASE_STEP = ADDR_W'(H_ACTIVE >> DECIM);
   localparam bit                DEC       = (DECIM != 0);

   typedef enum logic [1:0] {WAIT_VSYNC, SYNC, ACTIVE} state_t;

   state_t             state;
   logic               href_q;
   logic               vsync_q;
   logic [ROW_W-1:0]   row_cnt;
   logic [ADDR_W-1:0]  line_base;
   logic               first_line;

   logic               href_rise;
   logic               vsync_rise;
   logic               vsync_fall;
   logic               in_range;
   logic               keep;
   logic               drop;
   logic               base_step_en;
   logic [ADDR_W-1:0]  pix_addr;

   assign href_rise  = href & ~href_q;
   assign vsync_rise = vsync & ~vsync_q;
   assign vsync_fall = ~vsync & vsync_q;

   // Pixel qualification always uses the pre-advance row and base.
   assign in_range = (row_cnt < ROW_W'(V_ACTIVE)) & (pix_col < COL_W'(H_ACTIVE));
   assign keep     = (state == ACTIVE) & pix_valid & in_range &
                     (~DEC | (~row_cnt[0] & ~pix_col[0]));
   assign drop     = (state == ACTIVE) & pix_valid & ~in_range;
   assign pix_addr = line_base + ADDR_W'(pix_col >> DECIM);

   // Decimated base only moves when leaving an odd row, so row pairs share a base.
   assign base_step_en = ~DEC | row_cnt[0];

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= WAIT_VSYNC;
         href_q      <= 1'b0;
         vsync_q     <= 1'b0;
         row_cnt     <= '0;
         line_base   <= '0;
         first_line  <= 1'b1;
         fb_addr     <= '0;
         fb_data     <= '0;
         fb_we       <= 1'b0;
         frame_done  <= 1'b0;
         frame_short <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         href_q     <= href;
         vsync_q    <= vsync;
         fb_we      <= 1'b0;
         frame_done <= 1'b0;

         if (keep) begin
            fb_we   <= 1'b1;
            fb_data <= pix_rgb;
            fb_addr <= pix_addr;
         end
         if (drop) begin
            overflow <= 1'b1;
         end

         case (state)
            WAIT_VSYNC: begin
               if (vsync_rise) begin
                  state <= SYNC;
               end
            end
            SYNC: begin
               if (vsync_fall) begin
                  state      <= ACTIVE;
                  row_cnt    <= '0;
                  line_base  <= '0;
                  first_line <= 1'b1;
                  overflow   <= 1'b0;
               end
            end
            ACTIVE: begin
               if (vsync_rise) begin
                  state       <= SYNC;
                  frame_done  <= 1'b1;
                  frame_short <= first_line |
                                 (({1'b0, row_cnt} + 10'd1) != 10'(V_ACTIVE));
               end else if (href_rise) begin
                  if (first_line) begin
                     first_line <= 1'b0;
                  end else if (row_cnt != ROW_MAX) begin
                     row_cnt <= row_cnt + ROW_W'(1);
                     if (base_step_en) begin
                        line_base <= line_base + BASE_STEP;
                     end
                  end
               end
            end
            default: state <= WAIT_VSYNC;
         endcase
      end
   end

endmodule

// File: tb/tb_frame_writer.sv
// Bench for frame_writer: full-resolution and decimating instances share one randomized
// camera stream; writes are predicted from line/column numbers alone.
module tb_frame_writer;

   localparam int H  = 16;
   localparam int V  = 12;
   localparam int AW = 17;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          vsync = 1'b0;
   logic          href = 1'b0;
   logic          pix_valid = 1'b0;
   logic [11:0]   pix_rgb = '0;
   logic [9:0]    pix_col = '0;

   logic [AW-1:0] fb_addr0, fb_addr1;
   logic [11:0]   fb_data0, fb_data1;
   logic          fb_we0, fb_we1, done0, done1, short0, short1, ovf0, ovf1;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   bit model_on = 1'b1;
   bit exp_ovf = 1'b0;

   typedef struct {logic [AW-1:0] addr; logic [11:0] data; int cyc;} wr_t;
   typedef struct {logic s0; logic s1; logic o0; logic o1; logic both;} done_t;

   wr_t   exp0[$], exp1[$], obs0[$], obs1[$];
   done_t dones[$];
   wr_t   mon_w;
   done_t mon_d;

   always #5 clk = ~clk;

   frame_writer #(.H_ACTIVE(H), .V_ACTIVE(V), .DECIM(0), .ADDR_W(AW)) u_full (
      .pclk(clk), .rst_n(rst_n), .vsync(vsync), .href(href), .pix_rgb(pix_rgb),
      .pix_col(pix_col), .pix_valid(pix_valid), .fb_addr(fb_addr0), .fb_data(fb_data0),
      .fb_we(fb_we0), .frame_done(done0), .frame_short(short0), .overflow(ovf0));

   frame_writer #(.H_ACTIVE(H), .V_ACTIVE(V), .DECIM(1), .ADDR_W(AW)) u_dec (
      .pclk(clk), .rst_n(rst_n), .vsync(vsync), .href(href), .pix_rgb(pix_rgb),
      .pix_col(pix_col), .pix_valid(pix_valid), .fb_addr(fb_addr1), .fb_data(fb_data1),
      .fb_we(fb_we1), .frame_done(done1), .frame_short(short1), .overflow(ovf1));

   // Recorder only: logs what the write port and frame status did each cycle.
   always @(posedge clk) begin
      cyc++;
      #1;
      if (fb_we0) begin
         mon_w.addr = fb_addr0; mon_w.data = fb_data0; mon_w.cyc = cyc;
         obs0.push_back(mon_w);
      end
      if (fb_we1) begin
         mon_w.addr = fb_addr1; mon_w.data = fb_data1; mon_w.cyc = cyc;
         obs1.push_back(mon_w);
      end
      if (done0 | done1) begin
         mon_d.s0 = short0; mon_d.s1 = short1; mon_d.o0 = ovf0; mon_d.o1 = ovf1;
         mon_d.both = done0 & done1;
         dones.push_back(mon_d);
      end
   end

   // Reference: pixel (line l, column c) lands at l*H+c, or (l/2)*(H/2)+c/2 when decimating.
   function automatic void push_exp(input int l, input int c, input logic [11:0] d);
      wr_t w;
      if (!model_on) return;
      if (l >= V || c >= H) begin
         exp_ovf = 1'b1;
         return;
      end
      w.data = d;
      w.cyc  = cyc + 1;
      w.addr = AW'(l * H + c);
      exp0.push_back(w);
      if (l % 2 == 0 && c % 2 == 0) begin
         w.addr = AW'((l / 2) * (H / 2) + c / 2);
         exp1.push_back(w);
      end
   endfunction

   task automatic clear_all();
      exp0.delete(); exp1.delete(); obs0.delete(); obs1.delete(); dones.delete();
      exp_ovf = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         pix_valid = 1'b0;
      end
   endtask

   task automatic strobe(input int l, input int c);
      logic [11:0] d;
      d = 12'($urandom);
      @(negedge clk);
      pix_valid = 1'b1; pix_col = 10'(c); pix_rgb = d;
      push_exp(l, c, d);
   endtask

   // One camera line; sc >= 0 puts a strobe in the href-rise cycle (belongs to the previous row).
   task automatic send_line(input int l, input int n, input bit late, input int sc);
      logic [11:0] d;
      @(negedge clk);
      href = 1'b1; pix_valid = 1'b0;
      if (sc >= 0) begin
         d = 12'($urandom);
         pix_valid = 1'b1; pix_col = 10'(sc); pix_rgb = d;
         push_exp((l > 0) ? l - 1 : 0, sc, d);
      end
      for (int c = 0; c < n - (late ? 1 : 0); c++) begin
         if ($urandom_range(3) == 0) idle(1);
         strobe(l, c);
      end
      @(negedge clk);
      href = 1'b0; pix_valid = 1'b0;
      if (late) begin
         idle(1);
         strobe(l, n - 1);
      end
      idle(3);
   endtask

   // Ends the current frame and starts the next; pl >= 0 puts a strobe in the vsync-rise cycle.
   task automatic vsync_pulse(input int pl, input int pc);
      logic [11:0] d;
      @(negedge clk);
      vsync = 1'b1; href = 1'b0; pix_valid = 1'b0;
      if (pl >= 0) begin
         d = 12'($urandom);
         pix_valid = 1'b1; pix_col = 10'(pc); pix_rgb = d;
         push_exp(pl, pc, d);
      end
      idle(3);
      @(negedge clk);
      vsync = 1'b0; pix_valid = 1'b0;
      idle(3);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++;
      if ({fb_we0, fb_we1, done0, done1, short0, short1, ovf0, ovf1} !== 8'd0) begin
         errors++;
         $display("FAIL reset flags: got %b, expected 00000000",
                  {fb_we0, fb_we1, done0, done1, short0, short1, ovf0, ovf1});
      end
      checks++;
      if (fb_addr0 !== '0 || fb_addr1 !== '0 || fb_data0 !== '0 || fb_data1 !== '0) begin
         errors++;
         $display("FAIL reset bus: got addr %0d/%0d data %h/%h, expected all 0",
                  fb_addr0, fb_addr1, fb_data0, fb_data1);
      end
      rst_n = 1'b1;
      clear_all();
      model_on = 1'b0;
      send_line(0, H, 1'b0, -1);
      model_on = 1'b1;
      checks++;
      if (obs0.size() != 0 || obs1.size() != 0) begin
         errors++;
         $display("FAIL reset no_sync_writes: got %0d/%0d writes, expected 0/0", obs0.size(), obs1.size());
      end
      vsync_pulse(-1, 0);
      checks++;
      if (dones.size() != 0) begin
         errors++;
         $display("FAIL reset first_vsync_done: got %0d frame_done, expected 0", dones.size());
      end
   endtask

   task automatic test_full_frame();
      clear_all();
      for (int l = 0; l < V; l++) send_line(l, H, $urandom_range(1) == 1, -1);
      vsync_pulse(-1, 0);
      for (int k = 0; k < 2; k++) begin
         wr_t e[$];
         wr_t o[$];
         if (k == 0) begin e = exp0; o = obs0; end else begin e = exp1; o = obs1; end
         checks++;
         if (o.size() != e.size()) begin
            errors++;
            $display("FAIL full_frame count dut%0d: got %0d writes, expected %0d", k, o.size(), e.size());
         end
         for (int i = 0; i < e.size() && i < o.size(); i++) begin
            checks++;
            if (o[i].addr !== e[i].addr || o[i].data !== e[i].data || o[i].cyc != e[i].cyc) begin
               errors++;
               $display("FAIL full_frame write dut%0d #%0d: got addr=%0d data=%h cyc=%0d, expected addr=%0d data=%h cyc=%0d",
                        k, i, o[i].addr, o[i].data, o[i].cyc, e[i].addr, e[i].data, e[i].cyc);
            end
         end
      end
      checks++;
      if (obs0.size() == 0 || obs0[$].addr !== AW'(H * V - 1) ||
          obs1.size() == 0 || obs1[$].addr !== AW'(H * V / 4 - 1)) begin
         errors++;
         $display("FAIL full_frame last_addr: got %0d writes/%0d writes, expected last %0d/%0d",
                  obs0.size(), obs1.size(), H * V - 1, H * V / 4 - 1);
      end
      checks++;
      if (dones.size() != 1) begin
         errors++;
         $display("FAIL full_frame done_count: got %0d, expected 1", dones.size());
      end else begin
         checks++;
         if (dones[0].s0 !== 1'b0 || dones[0].s1 !== 1'b0 || dones[0].o0 !== 1'b0 ||
             dones[0].o1 !== 1'b0 || dones[0].both !== 1'b1) begin
            errors++;
            $display("FAIL full_frame status: got short=%b/%b ovf=%b/%b both=%b, expected short=0/0 ovf=0/0 both=1",
                     dones[0].s0, dones[0].s1, dones[0].o0, dones[0].o1, dones[0].both);
         end
      end
   endtask

   task automatic test_late_strobe();
      clear_all();
      for (int l = 0; l < 4; l++) send_line(l, H, 1'b1, -1);
      vsync_pulse(-1, 0);
      for (int k = 0; k < 2; k++) begin
         wr_t e[$];
         wr_t o[$];
         if (k == 0) begin e = exp0; o = obs0; end else begin e = exp1; o = obs1; end
         checks++;
         if (o.size() != e.size()) begin
            errors++;
            $display("FAIL late_strobe count dut%0d: got %0d writes, expected %0d", k, o.size(), e.size());
         end
         for (int i = 0; i < e.size() && i < o.size(); i++) begin
            checks++;
            if (o[i].addr !== e[i].addr || o[i].data !== e[i].data || o[i].cyc != e[i].cyc) begin
               errors++;
               $display("FAIL late_strobe write dut%0d #%0d: got addr=%0d data=%h cyc=%0d, expected addr=%0d data=%h cyc=%0d",
                        k, i, o[i].addr, o[i].data, o[i].cyc, e[i].addr, e[i].data, e[i].cyc);
            end
         end
      end
      checks++;
      if (dones.size() != 1 || dones[0].s0 !== 1'b1 || dones[0].s1 !== 1'b1) begin
         errors++;
         $display("FAIL late_strobe short: got %0d done pulses, expected 1 with short=1/1", dones.size());
      end
   endtask

   task automatic test_edges();
      clear_all();
      send_line(0, H, 1'b0, -1);
      send_line(1, H, 1'b0, 2);
      send_line(2, H, 1'b0, -1);
      vsync_pulse(2, 4);
      vsync_pulse(-1, 0);
      for (int k = 0; k < 2; k++) begin
         wr_t e[$];
         wr_t o[$];
         if (k == 0) begin e = exp0; o = obs0; end else begin e = exp1; o = obs1; end
         checks++;
         if (o.size() != e.size()) begin
            errors++;
            $display("FAIL edges count dut%0d: got %0d writes, expected %0d", k, o.size(), e.size());
         end
         for (int i = 0; i < e.size() && i < o.size(); i++) begin
            checks++;
            if (o[i].addr !== e[i].addr || o[i].data !== e[i].data || o[i].cyc != e[i].cyc) begin
               errors++;
               $display("FAIL edges write dut%0d #%0d: got addr=%0d data=%h cyc=%0d, expected addr=%0d data=%h cyc=%0d",
                        k, i, o[i].addr, o[i].data, o[i].cyc, e[i].addr, e[i].data, e[i].cyc);
            end
         end
      end
      checks++;
      if (dones.size() != 2) begin
         errors++;
         $display("FAIL edges done_count: got %0d, expected 2", dones.size());
      end else begin
         checks++;
         if (dones[0].s0 !== 1'b1 || dones[0].o0 !== 1'b0 || dones[1].s0 !== 1'b1 ||
             dones[1].s1 !== 1'b1 || dones[1].o1 !== 1'b0) begin
            errors++;
            $display("FAIL edges status: got short=%b,%b/%b ovf=%b/%b, expected short=1,1/1 ovf=0/0",
                     dones[0].s0, dones[1].s0, dones[1].s1, dones[0].o0, dones[1].o1);
         end
      end
   endtask

   task automatic test_long_frame();
      clear_all();
      for (int l = 0; l <= V; l++) send_line(l, H, 1'b0, -1);
      vsync_pulse(-1, 0);
      for (int k = 0; k < 2; k++) begin
         wr_t e[$];
         wr_t o[$];
         if (k == 0) begin e = exp0; o = obs0; end else begin e = exp1; o = obs1; end
         checks++;
         if (o.size() != e.size()) begin
            errors++;
            $display("FAIL long_frame count dut%0d: got %0d writes, expected %0d", k, o.size(), e.size());
         end
         for (int i = 0; i < e.size() && i < o.size(); i++) begin
            checks++;
            if (o[i].addr !== e[i].addr || o[i].data !== e[i].data || o[i].cyc != e[i].cyc) begin
               errors++;
               $display("FAIL long_frame write dut%0d #%0d: got addr=%0d data=%h cyc=%0d, expected addr=%0d data=%h cyc=%0d",
                        k, i, o[i].addr, o[i].data, o[i].cyc, e[i].addr, e[i].data, e[i].cyc);
            end
         end
      end
      checks++;
      if (dones.size() != 1 || dones[0].s0 !== 1'b1 || dones[0].s1 !== 1'b1 ||
          dones[0].o0 !== exp_ovf || dones[0].o1 !== exp_ovf) begin
         errors++;
         $display("FAIL long_frame status: got %0d done pulses, expected 1 with short=1/1 ovf=%b/%b",
                  dones.size(), exp_ovf, exp_ovf);
      end
      checks++;
      if (ovf0 !== 1'b0 || ovf1 !== 1'b0) begin
         errors++;
         $display("FAIL long_frame ovf_clear: got overflow=%b/%b after vsync fall, expected 0/0", ovf0, ovf1);
      end
   endtask

   task automatic test_short_badcol();
      clear_all();
      send_line(0, H, 1'b0, -1);
      send_line(1, H, 1'b0, -1);
      send_line(2, H, 1'b0, -1);
      strobe(2, 700);
      idle(2);
      checks++;
      if (ovf0 !== exp_ovf || ovf1 !== exp_ovf) begin
         errors++;
         $display("FAIL badcol overflow: got %b/%b, expected %b/%b", ovf0, ovf1, exp_ovf, exp_ovf);
      end
      send_line(3, H, 1'b0, -1);
      send_line(4, H, 1'b0, -1);
      vsync_pulse(-1, 0);
      for (int k = 0; k < 2; k++) begin
         wr_t e[$];
         wr_t o[$];
         if (k == 0) begin e = exp0; o = obs0; end else begin e = exp1; o = obs1; end
         checks++;
         if (o.size() != e.size()) begin
            errors++;
            $display("FAIL badcol count dut%0d: got %0d writes, expected %0d", k, o.size(), e.size());
         end
         for (int i = 0; i < e.size() && i < o.size(); i++) begin
            checks++;
            if (o[i].addr !== e[i].addr || o[i].data !== e[i].data || o[i].cyc != e[i].cyc) begin
               errors++;
               $display("FAIL badcol write dut%0d #%0d: got addr=%0d data=%h cyc=%0d, expected addr=%0d data=%h cyc=%0d",
                        k, i, o[i].addr, o[i].data, o[i].cyc, e[i].addr, e[i].data, e[i].cyc);
            end
         end
      end
      checks++;
      if (dones.size() != 1 || dones[0].s0 !== 1'b1 || dones[0].s1 !== 1'b1 ||
          dones[0].o0 !== 1'b1 || dones[0].o1 !== 1'b1) begin
         errors++;
         $display("FAIL badcol status: got %0d done pulses, expected 1 with short=1/1 ovf=1/1", dones.size());
      end
   endtask

   task automatic test_reset_mid_frame();
      clear_all();
      send_line(0, H, 1'b0, -1);
      @(negedge clk);
      href = 1'b1;
      strobe(1, 3);
      strobe(1, 700);
      strobe(1, 4);
      @(negedge clk);
      pix_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({fb_we0, fb_we1, ovf0, ovf1} !== 4'd0 || fb_addr0 !== '0 || fb_data0 !== '0 ||
          fb_addr1 !== '0 || fb_data1 !== '0) begin
         errors++;
         $display("FAIL reset_mid clear: got we=%b/%b ovf=%b/%b addr=%0d/%0d, expected all 0",
                  fb_we0, fb_we1, ovf0, ovf1, fb_addr0, fb_addr1);
      end
      @(negedge clk);
      rst_n = 1'b1; href = 1'b0;
      clear_all();
      model_on = 1'b0;
      for (int l = 0; l < 3; l++) send_line(l, H, 1'b0, -1);
      model_on = 1'b1;
      checks++;
      if (obs0.size() != 0 || obs1.size() != 0) begin
         errors++;
         $display("FAIL reset_mid no_resume: got %0d/%0d writes before vsync, expected 0/0",
                  obs0.size(), obs1.size());
      end
      vsync_pulse(-1, 0);
      for (int l = 0; l < V; l++) send_line(l, H, 1'b0, -1);
      vsync_pulse(-1, 0);
      for (int k = 0; k < 2; k++) begin
         wr_t e[$];
         wr_t o[$];
         if (k == 0) begin e = exp0; o = obs0; end else begin e = exp1; o = obs1; end
         checks++;
         if (o.size() != e.size()) begin
            errors++;
            $display("FAIL reset_mid count dut%0d: got %0d writes, expected %0d", k, o.size(), e.size());
         end
         for (int i = 0; i < e.size() && i < o.size(); i++) begin
            checks++;
            if (o[i].addr !== e[i].addr || o[i].data !== e[i].data || o[i].cyc != e[i].cyc) begin
               errors++;
               $display("FAIL reset_mid write dut%0d #%0d: got addr=%0d data=%h cyc=%0d, expected addr=%0d data=%h cyc=%0d",
                        k, i, o[i].addr, o[i].data, o[i].cyc, e[i].addr, e[i].data, e[i].cyc);
            end
         end
      end
      checks++;
      if (obs0.size() == 0 || obs0[0].addr !== '0 || obs1.size() == 0 || obs1[0].addr !== '0) begin
         errors++;
         $display("FAIL reset_mid first_addr: got %0d/%0d writes, expected first addr 0 on both",
                  obs0.size(), obs1.size());
      end
      checks++;
      if (dones.size() != 1 || dones[0].s0 !== 1'b0 || dones[0].o0 !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid status: got %0d done pulses, expected 1 with short=0 ovf=0", dones.size());
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_full_frame();
      test_late_strobe();
      test_edges();
      test_long_frame();
      test_short_badcol();
      test_reset_mid_frame();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
